// File: rtl/reg_wr_sched.sv
// reg_wr_sched: round-robin write scheduler for the shared register bank.
// Grants one requester per cycle. It drives a one-hot register enable and the
// shared write data, and returns a one-cycle ack (with error flag) to the requester.
// Optional feature macro: REG_WR_SCHED_WPROT_EN. When it is defined, the block
// adds a per-register write-protect input that blocks every requester except 0.
module reg_wr_sched #(
    parameter int NREQ = 2,
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
`ifdef REG_WR_SCHED_WPROT_EN
    input  logic [NREG-1:0]    wprot,
`endif
    output logic [NREQ-1:0]    req_ack,
    output logic [NREQ-1:0]    req_err,
    output logic [NREG-1:0]    reg_en,
    output logic [DW-1:0]      reg_data,
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_ack;
    logic [NREQ-1:0] r_err;
    logic [NREG-1:0] r_en;
    logic [DW-1:0]   r_data;

    logic [NREQ-1:0] w_elig;
    logic            w_gnt_vld;
    logic [PW-1:0]   w_gnt_idx;
    logic [PW-1:0]   w_ptr_nxt;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            w_in_range;
    logic            w_prot_hit;
    logic            w_ok;
    logic [NREG-1:0] w_en_nxt;
    logic [NREQ-1:0] w_ack_nxt;

    // A requester being acked right now is still holding valid; mask it so
    // the same write is never issued twice.
    assign w_elig = req_valid & ~r_ack;

    // Round-robin search: first eligible index at or after ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_ptr_nxt = r_ptr;
        w_addr    = '0;
        w_data    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_gnt_vld && w_elig[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PW'(idx);
                w_ptr_nxt = (idx + 1 >= NREQ) ? '0 : PW'(idx + 1);
                w_addr    = req_addr[idx*AW +: AW];
                w_data    = req_data[idx*DW +: DW];
            end
        end
    end

    // Decide whether the granted write may touch the bank, and build the
    // next enable and ack vectors.
    always_comb begin
        w_in_range = (32'(w_addr) < 32'(NREG));
        w_prot_hit = 1'b0;
`ifdef REG_WR_SCHED_WPROT_EN
        // Requester 0 (APB) always bypasses write protection.
        for (int j = 0; j < NREG; j++) begin
            if (32'(w_addr) == 32'(j) && wprot[j] && (w_gnt_idx != '0))
                w_prot_hit = 1'b1;
        end
`endif
        w_ok = w_in_range && !w_prot_hit;
        for (int j = 0; j < NREG; j++)
            w_en_nxt[j] = w_gnt_vld && w_ok && (32'(w_addr) == 32'(j));
        for (int i = 0; i < NREQ; i++)
            w_ack_nxt[i] = w_gnt_vld && (w_gnt_idx == PW'(i));
    end

    // Register the grant; reset drops any grant pending in this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_ack  <= '0;
            r_err  <= '0;
            r_en   <= '0;
            r_data <= '0;
        end else begin
            r_ack <= w_ack_nxt;
            r_err <= w_ack_nxt & {NREQ{~w_ok}};
            r_en  <= w_en_nxt;
            if (w_gnt_vld) begin
                r_data <= w_data;
                r_ptr  <= w_ptr_nxt;
            end
        end
    end

    assign req_ack  = r_ack;
    assign req_err  = r_err;
    assign reg_en   = r_en;
    assign reg_data = r_data;
    assign busy     = (|req_valid) | (|r_en) | (|r_ack);

endmodule
